rr_selector: RTL and testbench



---
 rtl/rr_selector.sv | 149 ++++++++++++++
 tb/tb_rr_selector.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rr_selector.sv
// rr_selector: registered round-robin selector.
// Picks one active requester per cycle, captures its data and index into a
// one-entry output register behind a valid/ready handshake, and pulses a
// combinational grant for the captured element.
// Build option: define RR_SELECTOR_RR_EN for rotating priority; when it is
// undefined the search always starts at the fixed end (index 0 searching
// upward, or IN-1 searching downward) and no pointer state exists.
module rr_selector #(
  parameter int    DATA    = 8,
  parameter int    IN      = 4,
  parameter string ACT     = "High",
  parameter string MSB     = "Disable",
  parameter int    LOG2_IN = (IN > 1) ? $clog2(IN) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IN-1:0]            req,
  input  logic [IN-1:0][DATA-1:0]  in,
  output logic [IN-1:0]            grant,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA-1:0]          out_data,
  output logic [LOG2_IN-1:0]       out_idx
);

  localparam bit ACT_LOW  = (ACT == "Low");
  localparam bit MSB_DOWN = (MSB == "Enable");

  localparam logic [LOG2_IN-1:0] LAST_IDX = LOG2_IN'(IN - 1);
  localparam logic [LOG2_IN-1:0] ONE_IDX  = LOG2_IN'(1);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [IN-1:0]      req_act_s;
  logic [IN-1:0]      grant_act_s;
  logic               found_s;
  logic [LOG2_IN-1:0] win_s;
  logic [LOG2_IN-1:0] start_s;
  logic               load_s;
  logic [0:0]         state_r;

  // Normalise request polarity so the search always works on active-high bits.
  assign req_act_s = ACT_LOW ? ~req : req;

`ifdef RR_SELECTOR_RR_EN
  logic [LOG2_IN-1:0] ptr_r;
  logic [LOG2_IN-1:0] ptr_nxt_s;

  assign start_s = ptr_r;

  // Next pointer: the element just past the winner in the search direction.
  always_comb begin
    ptr_nxt_s = win_s;
    if (MSB_DOWN) begin
      if (win_s == '0) begin
        ptr_nxt_s = LAST_IDX;
      end else begin
        ptr_nxt_s = win_s - ONE_IDX;
      end
    end else begin
      if (win_s == LAST_IDX) begin
        ptr_nxt_s = '0;
      end else begin
        ptr_nxt_s = win_s + ONE_IDX;
      end
    end
  end

  // Rotating-priority pointer; advances only when an entry is captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= MSB_DOWN ? LAST_IDX : '0;
    end else if (load_s) begin
      ptr_r <= ptr_nxt_s;
    end
  end
`else
  assign start_s = MSB_DOWN ? LAST_IDX : '0;
`endif

  // Winner search from start_s in the configured direction, wrapping within 0..IN-1.
  always_comb begin
    int cand_v;
    cand_v  = 0;
    found_s = 1'b0;
    win_s   = '0;
    for (int k = 0; k < IN; k++) begin
      if (MSB_DOWN) begin
        cand_v = (int'(start_s) + IN - k) % IN;
      end else begin
        cand_v = (int'(start_s) + k) % IN;
      end
      if (!found_s && req_act_s[LOG2_IN'(cand_v)]) begin
        found_s = 1'b1;
        win_s   = LOG2_IN'(cand_v);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Capture when a request exists and the register is empty or draining; never during reset.
  assign load_s = found_s && (!out_valid || out_ready) && !reset;

  // One-hot grant for the captured element, then mapped to the configured polarity.
  always_comb begin
    grant_act_s = '0;
    for (int i = 0; i < IN; i++) begin
      grant_act_s[i] = load_s && (win_s == LOG2_IN'(i));
    end
  end

  assign grant = ACT_LOW ? ~grant_act_s : grant_act_s;

  // Output register state machine: EMPTY/FULL with load overriding drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_EMPTY;
      out_data <= '0;
      out_idx  <= '0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (load_s) begin
            state_r  <= ST_FULL;
            out_data <= in[win_s];
            out_idx  <= win_s;
          end
        end
        ST_FULL: begin
          if (load_s) begin
            state_r  <= ST_FULL;
            out_data <= in[win_s];
            out_idx  <= win_s;
          end else if (out_ready) begin
            state_r  <= ST_EMPTY;
          end
        end
        default: begin
          state_r <= ST_EMPTY;
        end
      endcase
    end
  end

  assign out_valid = (state_r == ST_FULL);

endmodule

// File: tb/tb_rr_selector.sv
// tb_rr_selector: table-driven checks of rr_selector (IN=4, LSB, active-high)
// plus hand-written sequences for asynchronous reset and an IN=5,
// active-low, downward-search instance. Expectations follow the build option
// RR_SELECTOR_RR_EN (rotating vs fixed priority).
module tb_rr_selector;

`ifdef RR_SELECTOR_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             clk;
  logic             reset;

  logic [3:0]       req_a;
  logic [3:0][7:0]  in_a;
  logic [3:0]       grant_a;
  logic             valid_a;
  logic             rdy_a;
  logic [7:0]       data_a;
  logic [1:0]       idx_a;

  logic [4:0]       req_b;
  logic [4:0][7:0]  in_b;
  logic [4:0]       grant_b;
  logic             valid_b;
  logic             rdy_b;
  logic [7:0]       data_b;
  logic [2:0]       idx_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] grant;
    logic       valid;
    logic [1:0] idx;
    logic [7:0] data;
  } vec_t;

  vec_t tbl [19];

  rr_selector #(.DATA(8), .IN(4), .ACT("High"), .MSB("Disable")) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .in(in_a), .grant(grant_a),
    .out_valid(valid_a), .out_ready(rdy_a), .out_data(data_a), .out_idx(idx_a)
  );

  rr_selector #(.DATA(8), .IN(5), .ACT("Low"), .MSB("Enable")) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .in(in_b), .grant(grant_b),
    .out_valid(valid_b), .out_ready(rdy_b), .out_data(data_b), .out_idx(idx_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    in_a  = {8'h33, 8'h22, 8'h11, 8'h00};
    in_b  = {8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
    reset = 1'b1;
    req_a = 4'b0000;
    rdy_a = 1'b0;
    req_b = 5'b11111;
    rdy_b = 1'b1;

    // Rotation, idle, backpressure, wrap/skip and drain+load rows.
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001,                 1'b0, 2'd0,             8'h00};
    tbl[1]  = '{4'b1111, 1'b1, RR ? 4'b0010 : 4'b0001,  1'b1, 2'd0,             8'h00};
    tbl[2]  = '{4'b1111, 1'b1, RR ? 4'b0100 : 4'b0001,  1'b1, RR ? 2'd1 : 2'd0, RR ? 8'h11 : 8'h00};
    tbl[3]  = '{4'b1111, 1'b1, RR ? 4'b1000 : 4'b0001,  1'b1, RR ? 2'd2 : 2'd0, RR ? 8'h22 : 8'h00};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001,                 1'b1, RR ? 2'd3 : 2'd0, RR ? 8'h33 : 8'h00};
    tbl[5]  = '{4'b0000, 1'b1, 4'b0000,                 1'b1, 2'd0,             8'h00};
    tbl[6]  = '{4'b0000, 1'b1, 4'b0000,                 1'b0, 2'd0,             8'h00};
    tbl[7]  = '{4'b0010, 1'b0, 4'b0010,                 1'b0, 2'd0,             8'h00};
    tbl[8]  = '{4'b0100, 1'b0, 4'b0000,                 1'b1, 2'd1,             8'h11};
    tbl[9]  = '{4'b0100, 1'b0, 4'b0000,                 1'b1, 2'd1,             8'h11};
    tbl[10] = '{4'b0100, 1'b1, 4'b0100,                 1'b1, 2'd1,             8'h11};
    tbl[11] = '{4'b0000, 1'b0, 4'b0000,                 1'b1, 2'd2,             8'h22};
    tbl[12] = '{4'b0001, 1'b1, 4'b0001,                 1'b1, 2'd2,             8'h22};
    tbl[13] = '{4'b0011, 1'b1, RR ? 4'b0010 : 4'b0001,  1'b1, 2'd0,             8'h00};
    tbl[14] = '{4'b0000, 1'b1, 4'b0000,                 1'b1, RR ? 2'd1 : 2'd0, RR ? 8'h11 : 8'h00};
    tbl[15] = '{4'b0000, 1'b1, 4'b0000,                 1'b0, RR ? 2'd1 : 2'd0, RR ? 8'h11 : 8'h00};
    tbl[16] = '{4'b0010, 1'b0, 4'b0010,                 1'b0, RR ? 2'd1 : 2'd0, RR ? 8'h11 : 8'h00};
    tbl[17] = '{4'b0100, 1'b1, 4'b0100,                 1'b1, 2'd1,             8'h11};
    tbl[18] = '{4'b0000, 1'b0, 4'b0000,                 1'b1, 2'd2,             8'h22};

    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, both instances.
    chk("reset out_valid", 32'(valid_a), 32'd0);
    chk("reset out_data",  32'(data_a),  32'd0);
    chk("reset out_idx",   32'(idx_a),   32'd0);
    chk("reset grant",     32'(grant_a), 32'd0);
    chk("reset b grant",   32'(grant_b), 32'h1F);
    chk("reset b valid",   32'(valid_b), 32'd0);

    reset = 1'b0;
    for (int i = 0; i < 19; i++) begin
      req_a = tbl[i].req;
      rdy_a = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d grant", i),     32'(grant_a), 32'(tbl[i].grant));
      chk($sformatf("row%0d out_valid", i), 32'(valid_a), 32'(tbl[i].valid));
      chk($sformatf("row%0d out_idx", i),   32'(idx_a),   32'(tbl[i].idx));
      chk($sformatf("row%0d out_data", i),  32'(data_a),  32'(tbl[i].data));
      next_cycle();
    end

    // Asynchronous reset while FULL: outputs clear at once, no grant during reset.
    req_a = 4'b0001;
    rdy_a = 1'b0;
    reset = 1'b1;
    #1;
    chk("async reset out_valid", 32'(valid_a), 32'd0);
    chk("async reset out_data",  32'(data_a),  32'd0);
    chk("async reset out_idx",   32'(idx_a),   32'd0);
    chk("grant during reset",    32'(grant_a), 32'd0);
    next_cycle();
    chk("grant held in reset",   32'(grant_a), 32'd0);

    // First cycle after release: pointer back at 0, so idx 0 beats idx 3.
    reset = 1'b0;
    req_a = 4'b1001;
    rdy_a = 1'b1;
    #1;
    chk("post-reset grant", 32'(grant_a), 32'b0001);
    next_cycle();
    req_a = 4'b0000;
    #1;
    chk("post-reset out_valid", 32'(valid_a), 32'd1);
    chk("post-reset out_idx",   32'(idx_a),   32'd0);
    chk("post-reset out_data",  32'(data_a),  32'h00);
    next_cycle();

    // IN=5, active-low, downward search: idx 0 and 2 request, idx 2 wins.
    req_b = 5'b11010;
    rdy_b = 1'b1;
    #1;
    chk("b grant idx2", 32'(grant_b), 32'b11011);
    next_cycle();
    req_b = 5'b11111;
    #1;
    chk("b out_valid",    32'(valid_b), 32'd1);
    chk("b out_idx",      32'(idx_b),   32'd2);
    chk("b out_data",     32'(data_b),  32'hA2);
    chk("b idle grant",   32'(grant_b), 32'b11111);
    next_cycle();
    chk("b drained",      32'(valid_b), 32'd0);
    chk("b idle grant 2", 32'(grant_b), 32'b11111);
    next_cycle();
    chk("b stays empty",  32'(valid_b), 32'd0);
    chk("b idx holds",    32'(idx_b),   32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
